// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types, funct3/error encodings and the access legality check for the load/store unit.
package lsu_pkg;
    typedef enum logic [1:0] {IDLE, REQ, WAIT_R, DONE} lsu_state_t;
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [1:0] ERR_OK       = 2'b00;
    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_ILLEGAL  = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b11;
    // Illegal encodings win over misalignment; f3[1:0] distinguishes half (01) and word (10) widths.
    function automatic logic [1:0] check_access(input logic st, input logic [2:0] f3, input logic [1:0] a);
        logic ill;
        logic mis;
        ill = st ? (f3 > F3_W) : (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111);
        mis = (f3[1:0] == 2'b01 && a[0]) || (f3[1:0] == 2'b10 && a != 2'b00);
        return ill ? ERR_ILLEGAL : mis ? ERR_MISALIGN : ERR_OK;
    endfunction
endpackage

// File: rtl/lsu_if.sv
// lsu_if: core request/response and data-memory bus seen by the load/store unit.
interface lsu_if #(parameter int WIDTH = 32);
    logic             req_valid;
    logic             is_store;
    logic [2:0]       funct3;
    logic [WIDTH-1:0] addr;
    logic [WIDTH-1:0] wdata;
    logic             stall;
    logic             done;
    logic [WIDTH-1:0] rdata;
    logic [1:0]       err;
    logic             mem_req;
    logic             mem_we;
    logic [WIDTH-1:0] mem_addr;
    logic [3:0]       mem_wstrb;
    logic [WIDTH-1:0] mem_wdata;
    logic             mem_gnt;
    logic             mem_rvalid;
    logic [WIDTH-1:0] mem_rdata;
    modport slave (
        input  req_valid, is_store, funct3, addr, wdata, mem_gnt, mem_rvalid, mem_rdata,
        output stall, done, rdata, err, mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata
    );
    modport master (
        output req_valid, is_store, funct3, addr, wdata, mem_gnt, mem_rvalid, mem_rdata,
        input  stall, done, rdata, err, mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata
    );
endinterface

// File: rtl/lsu_load_extend.sv
// load_extend: selects the addressed byte/half of a memory word and sign- or zero-extends it.
module load_extend import lsu_pkg::*; (
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_offset,
    input  logic [31:0] i_rdata,
    output logic [31:0] o_data
);
    logic [7:0]  w_b;
    logic [15:0] w_h;
    always_comb begin
        w_b = i_rdata[8*i_offset +: 8];
        w_h = i_rdata[16*i_offset[1] +: 16];
        o_data = (i_funct3 == F3_B)  ? {{24{w_b[7]}}, w_b} :
                 (i_funct3 == F3_BU) ? {24'd0, w_b} :
                 (i_funct3 == F3_H)  ? {{16{w_h[15]}}, w_h} :
                 (i_funct3 == F3_HU) ? {16'd0, w_h} : i_rdata;
    end
endmodule

// File: rtl/lsu.sv
// lsu: converts one load/store per instruction into a word-aligned req/gnt/rvalid memory transaction,
// stalling the core until it retires; rdata feeds the writeback result mux.
module lsu import lsu_pkg::*; #(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 255
) (
    input logic  clk,
    input logic  reset,
    lsu_if.slave bus
);
    lsu_state_t       r_state;
    lsu_state_t       w_next;
    logic [WIDTH-1:0] r_addr;
    logic [WIDTH-1:0] r_wdata;
    logic [WIDTH-1:0] r_rdata;
    logic [2:0]       r_funct3;
    logic             r_store;
    logic [1:0]       r_err;
    logic [15:0]      r_cnt;
    logic [1:0]       w_chk;
    logic             w_tmo;
    logic [31:0]      w_ext;
    assign w_chk = check_access(bus.is_store, bus.funct3, bus.addr[1:0]);
    // >= so a grant in the last budget cycle still times out promptly in WAIT_R.
    assign w_tmo = r_cnt >= 16'(TIMEOUT - 1);
    load_extend u_ext (
        .i_funct3 (r_funct3),
        .i_offset (r_addr[1:0]),
        .i_rdata  (bus.mem_rdata),
        .o_data   (w_ext)
    );
    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = !bus.req_valid ? IDLE : (w_chk != ERR_OK) ? DONE : REQ;
            REQ:     w_next = bus.mem_gnt ? (r_store ? DONE : WAIT_R) : w_tmo ? DONE : REQ;
            WAIT_R:  w_next = (bus.mem_rvalid || w_tmo) ? DONE : WAIT_R;
            default: w_next = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rdata <= '0;
            r_err   <= ERR_OK;
            r_cnt   <= '0;
        end else begin
            if (r_state == IDLE && bus.req_valid) begin
                r_addr   <= bus.addr;
                r_funct3 <= bus.funct3;
                r_store  <= bus.is_store;
                r_wdata  <= bus.wdata;
                r_err    <= w_chk;
                r_cnt    <= '0;
            end
            if (r_state == REQ || r_state == WAIT_R) r_cnt <= r_cnt + 16'd1;
            if (r_state == REQ && !bus.mem_gnt && w_tmo) begin
                r_err <= ERR_TIMEOUT;
                if (!r_store) r_rdata <= '0;
            end
            if (r_state == WAIT_R && bus.mem_rvalid) r_rdata <= w_ext;
            else if (r_state == WAIT_R && w_tmo) begin
                r_err   <= ERR_TIMEOUT;
                r_rdata <= '0;
            end
        end
    end
    always_comb begin
        bus.stall     = (r_state == IDLE && bus.req_valid) || r_state == REQ || r_state == WAIT_R;
        bus.done      = r_state == DONE;
        bus.rdata     = r_rdata;
        bus.err       = r_err;
        bus.mem_req   = r_state == REQ;
        bus.mem_we    = r_state == REQ && r_store;
        bus.mem_addr  = {r_addr[WIDTH-1:2], 2'b00};
        bus.mem_wstrb = (r_state != REQ)    ? 4'b0000 :
                        (r_funct3 == F3_B)  ? 4'b0001 << r_addr[1:0] :
                        (r_funct3 == F3_H)  ? 4'b0011 << r_addr[1:0] : 4'b1111;
        bus.mem_wdata = (r_funct3 == F3_B) ? {4{r_wdata[7:0]}} :
                        (r_funct3 == F3_H) ? {2{r_wdata[15:0]}} : r_wdata;
    end
endmodule

// File: tb/tb_lsu.sv
// tb_lsu: directed vectors for lsu; expected retire results and memory requests go through scoreboard queues.
module tb_lsu;
    localparam int TMO = 4;
    typedef struct {
        logic [1:0]  err;
        logic [31:0] rdata;
    } done_t;
    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  strb;
        logic [31:0] wdata;
    } mem_t;
    typedef struct {
        logic        st;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] wd;
        int          gd;
        int          rd;
        logic        early;
        logic [31:0] mrd;
        logic [1:0]  e;
        logic [31:0] er;
        logic [3:0]  es;
        logic [31:0] ew;
        int          lat;
    } vec_t;
    logic  clk = 0;
    logic  reset = 1;
    int    total = 0;
    int    bad = 0;
    done_t exp_done[$];
    mem_t  exp_mem[$];
    vec_t  v[18];
    lsu_if #(.WIDTH(32)) bus ();
    lsu #(.WIDTH(32), .TIMEOUT(TMO)) dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;
    task automatic check(input string n, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, want %h (t=%0t)", n, act, exp, $time);
        end
    endtask
    always @(negedge clk) begin
        if (!reset) begin
            if (bus.done) begin
                if (exp_done.size() == 0) check("done_unexpected", 32'd1, 32'd0);
                else begin
                    done_t d;
                    d = exp_done.pop_front();
                    check("err", {30'd0, bus.err}, {30'd0, d.err});
                    check("rdata", bus.rdata, d.rdata);
                end
            end
            if (bus.mem_req && bus.mem_gnt) begin
                if (exp_mem.size() == 0) check("mem_unexpected", 32'd1, 32'd0);
                else begin
                    mem_t m;
                    m = exp_mem.pop_front();
                    check("mem_we", {31'd0, bus.mem_we}, {31'd0, m.we});
                    check("mem_addr", bus.mem_addr, m.addr);
                    if (m.we) begin
                        check("mem_wstrb", {28'd0, bus.mem_wstrb}, {28'd0, m.strb});
                        check("mem_wdata", bus.mem_wdata, m.wdata);
                    end
                end
            end
        end
    end
    task automatic run(input vec_t x);
        int gk, rk, lat, stalls, reqs, exp_reqs;
        gk = (x.gd < 0) ? -1 : 1 + x.gd;
        rk = (x.st || x.gd < 0) ? -1 : 2 + x.gd + x.rd;
        exp_reqs = (x.e == 2'b00) ? x.gd + 1 : (x.e == 2'b11) ? TMO : 0;
        lat = -1;
        stalls = 0;
        reqs = 0;
        exp_done.push_back('{x.e, x.er});
        if (x.e == 2'b00) exp_mem.push_back('{x.st, {x.a[31:2], 2'b00}, x.es, x.ew});
        @(posedge clk); #1;
        bus.req_valid = 1;
        bus.is_store  = x.st;
        bus.funct3    = x.f3;
        bus.addr      = x.a;
        bus.wdata     = x.wd;
        for (int k = 0; k < 30; k++) begin
            bus.mem_gnt    = (k == gk);
            bus.mem_rvalid = (k == rk) || (x.early && k == gk);
            bus.mem_rdata  = (x.early && k == gk) ? ~x.mrd : x.mrd;
            @(negedge clk);
            if (bus.stall) stalls++;
            if (bus.mem_req) reqs++;
            if (bus.done) begin
                lat = k;
                break;
            end
            @(posedge clk); #1;
        end
        check("latency", lat, x.lat);
        check("stall_cycles", stalls, x.lat);
        check("req_cycles", reqs, exp_reqs);
        @(posedge clk); #1;
        bus.req_valid  = 0;
        bus.mem_gnt    = 0;
        bus.mem_rvalid = 0;
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog: got running, want finished");
        $fatal(1);
    end
    initial begin
        v = '{
            '{1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 1, 0, 1'b0, 32'h0,        2'b00, 32'h0,        4'b1111, 32'hDEADBEEF, 3},
            '{1'b1, 3'b000, 32'h103, 32'h000000A5, 0, 0, 1'b0, 32'h0,        2'b00, 32'h0,        4'b1000, 32'hA5A5A5A5, 2},
            '{1'b1, 3'b001, 32'h102, 32'h1234BEEF, 0, 0, 1'b0, 32'h0,        2'b00, 32'h0,        4'b1100, 32'hBEEFBEEF, 2},
            '{1'b0, 3'b000, 32'h202, 32'h0,        0, 0, 1'b0, 32'h12F03456, 2'b00, 32'hFFFFFFF0, 4'b0,    32'h0,        3},
            '{1'b0, 3'b100, 32'h202, 32'h0,        0, 0, 1'b0, 32'h12F03456, 2'b00, 32'h000000F0, 4'b0,    32'h0,        3},
            '{1'b0, 3'b101, 32'h202, 32'h0,        0, 0, 1'b0, 32'h12F03456, 2'b00, 32'h000012F0, 4'b0,    32'h0,        3},
            '{1'b0, 3'b001, 32'h200, 32'h0,        0, 2, 1'b0, 32'h12348001, 2'b00, 32'hFFFF8001, 4'b0,    32'h0,        5},
            '{1'b0, 3'b010, 32'h201, 32'h0,        0, 0, 1'b0, 32'h0,        2'b01, 32'hFFFF8001, 4'b0,    32'h0,        1},
            '{1'b0, 3'b011, 32'h200, 32'h0,        0, 0, 1'b0, 32'h0,        2'b10, 32'hFFFF8001, 4'b0,    32'h0,        1},
            '{1'b0, 3'b111, 32'h200, 32'h0,        0, 0, 1'b0, 32'h0,        2'b10, 32'hFFFF8001, 4'b0,    32'h0,        1},
            '{1'b1, 3'b011, 32'h200, 32'h0,        0, 0, 1'b0, 32'h0,        2'b10, 32'hFFFF8001, 4'b0,    32'h0,        1},
            '{1'b1, 3'b001, 32'h101, 32'h0,        0, 0, 1'b0, 32'h0,        2'b01, 32'hFFFF8001, 4'b0,    32'h0,        1},
            '{1'b0, 3'b010, 32'h204, 32'h0,        0, 0, 1'b0, 32'hCAFEF00D, 2'b00, 32'hCAFEF00D, 4'b0,    32'h0,        3},
            '{1'b0, 3'b010, 32'h208, 32'h0,       -1, 0, 1'b0, 32'h0,        2'b11, 32'h0,        4'b0,    32'h0,        5},
            '{1'b0, 3'b010, 32'h208, 32'h0,        0, 0, 1'b0, 32'h55667788, 2'b00, 32'h55667788, 4'b0,    32'h0,        3},
            '{1'b1, 3'b010, 32'h20C, 32'h11112222,-1, 0, 1'b0, 32'h0,        2'b11, 32'h55667788, 4'b0,    32'h0,        5},
            '{1'b0, 3'b010, 32'h20C, 32'h0,        0, 0, 1'b1, 32'h0F0F1234, 2'b00, 32'h0F0F1234, 4'b0,    32'h0,        3},
            '{1'b0, 3'b101, 32'h203, 32'h0,        0, 0, 1'b0, 32'h0,        2'b01, 32'h0F0F1234, 4'b0,    32'h0,        1}
        };
        bus.req_valid = 0; bus.is_store = 0; bus.funct3 = 0; bus.addr = 0; bus.wdata = 0;
        bus.mem_gnt = 0; bus.mem_rvalid = 0; bus.mem_rdata = 0;
        repeat (3) @(posedge clk);
        #1 reset = 0;
        @(negedge clk);
        check("rst_stall", {31'd0, bus.stall}, 32'd0);
        check("rst_done", {31'd0, bus.done}, 32'd0);
        check("rst_mem_req", {31'd0, bus.mem_req}, 32'd0);
        check("rst_mem_we", {31'd0, bus.mem_we}, 32'd0);
        check("rst_wstrb", {28'd0, bus.mem_wstrb}, 32'd0);
        check("rst_rdata", bus.rdata, 32'd0);
        check("rst_err", {30'd0, bus.err}, 32'd0);
        for (int i = 0; i < 18; i++) run(v[i]);
        exp_mem.push_back('{1'b0, 32'h300, 4'b0, 32'h0});
        @(posedge clk); #1;
        bus.req_valid = 1; bus.is_store = 0; bus.funct3 = 3'b010; bus.addr = 32'h300;
        @(posedge clk); #1;
        bus.mem_gnt = 1;
        @(posedge clk); #1;
        bus.mem_gnt = 0;
        reset = 1;
        @(posedge clk); #1;
        reset = 0;
        bus.req_valid = 0;
        bus.mem_gnt = 1;
        bus.mem_rvalid = 1;
        bus.mem_rdata = 32'hAAAAAAAA;
        @(negedge clk);
        check("post_rst_mem_req", {31'd0, bus.mem_req}, 32'd0);
        @(posedge clk); #1;
        bus.mem_gnt = 0;
        bus.mem_rvalid = 0;
        @(negedge clk);
        check("post_rst_stall", {31'd0, bus.stall}, 32'd0);
        check("post_rst_done", {31'd0, bus.done}, 32'd0);
        check("post_rst_rdata", bus.rdata, 32'd0);
        check("post_rst_err", {30'd0, bus.err}, 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("scoreboard_left", exp_done.size() + exp_mem.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
